// File: rtl/mcu_exec_core.sv
// Multi-cycle MCU execution core: LOAD/FETCH/DECODE/EXECUTE sequencer with
// accumulator, status flags, program counter and a 16-mode 8-bit ALU.
module mcu_exec_core #(
  parameter logic [1:0] ST_LOAD    = 2'b00,
  parameter logic [1:0] ST_FETCH   = 2'b01,
  parameter logic [1:0] ST_DECODE  = 2'b10,
  parameter logic [1:0] ST_EXECUTE = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_done,
  input  logic [11:0] instr,
  input  logic [7:0]  data_in,
  output logic [1:0]  state,
  output logic [7:0]  pc,
  output logic [7:0]  acc,
  output logic [3:0]  status,
  output logic [7:0]  alu_result,
  output logic        pmem_load_en,
  output logic        ir_en,
  output logic        pmem_en,
  output logic        dr_en,
  output logic        dmem_en,
  output logic        dmem_we
);

  typedef enum logic [1:0] {
    StLoad    = ST_LOAD,
    StFetch   = ST_FETCH,
    StDecode  = ST_DECODE,
    StExecute = ST_EXECUTE
  } state_e;

  state_e      r_state, w_state_d;
  logic [7:0]  r_pc, r_acc, w_pc_d, w_acc_d, w_pc_inc;
  logic [3:0]  r_status, w_status_d, w_flags;
  logic        w_alu_en, w_c, w_o;
  logic [3:0]  w_mode;
  logic [7:0]  w_op2, w_res, w_rol, w_ror, w_sra;
  logic [2:0]  w_sh;

  // Returns {overflow, carry/borrow, result} for a +/- b.
  function automatic logic [9:0] f_addsub(input logic [7:0] a, input logic [7:0] b,
                                          input logic sub);
    logic [8:0] r;
    logic       o;
    r = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    o = sub ? ((a[7] != b[7]) && (r[7] != a[7])) : ((a[7] == b[7]) && (r[7] != a[7]));
    return {o, r};
  endfunction

  assign state    = r_state;
  assign pc       = r_pc;
  assign acc      = r_acc;
  assign status   = r_status;
  assign w_pc_inc = r_pc + 8'd1;

  // ALU runs only for I-type and M-type instructions in EXECUTE.
  assign w_alu_en = (r_state == StExecute) && (instr[11] || (!instr[10] && instr[9]));
  assign w_mode   = instr[11] ? {1'b0, instr[10:8]} : instr[7:4];
  assign w_op2    = instr[11] ? instr[7:0] : data_in;
  assign w_sh     = r_acc[2:0];
  assign w_rol    = 8'(({w_op2, w_op2} << w_sh) >> 8);
  assign w_ror    = 8'({w_op2, w_op2} >> w_sh);
  assign w_sra    = $signed(w_op2) >>> w_sh;

  always_comb begin
    w_res = 8'h00;
    w_c   = 1'b0;
    w_o   = 1'b0;
    case (w_mode)
      4'h0:    {w_o, w_c, w_res} = f_addsub(r_acc, w_op2, 1'b0);
      4'h1:    {w_o, w_c, w_res} = f_addsub(r_acc, w_op2, 1'b1);
      4'h2:    w_res = r_acc;
      4'h3:    w_res = w_op2;
      4'h4:    w_res = r_acc & w_op2;
      4'h5:    w_res = r_acc | w_op2;
      4'h6:    w_res = r_acc ^ w_op2;
      4'h7:    {w_o, w_c, w_res} = f_addsub(w_op2, r_acc, 1'b1);
      4'h8:    {w_o, w_c, w_res} = f_addsub(w_op2, 8'h01, 1'b0);
      4'h9:    {w_o, w_c, w_res} = f_addsub(w_op2, 8'h01, 1'b1);
      4'hA:    w_res = w_rol;
      4'hB:    w_res = w_ror;
      4'hC:    w_res = w_op2 << w_sh;
      4'hD:    w_res = w_op2 >> w_sh;
      4'hE:    w_res = w_sra;
      default: {w_o, w_c, w_res} = f_addsub(8'h00, w_op2, 1'b1);
    endcase
  end

  assign alu_result = w_alu_en ? w_res : r_acc;
  assign w_flags    = w_alu_en ? {(w_res == 8'h00), w_c, w_res[7], w_o} : r_status;

  always_comb begin
    w_state_d    = r_state;
    pmem_load_en = 1'b0;
    ir_en        = 1'b0;
    pmem_en      = 1'b0;
    dr_en        = 1'b0;
    dmem_en      = 1'b0;
    dmem_we      = 1'b0;
    unique case (r_state)
      StLoad: begin
        pmem_load_en = 1'b1;
        if (load_done) w_state_d = StFetch;
      end
      StFetch: begin
        ir_en     = 1'b1;
        pmem_en   = 1'b1;
        w_state_d = StDecode;
      end
      StDecode: begin
        if (instr[11:9] == 3'b001) begin
          dr_en   = 1'b1;
          dmem_en = 1'b1;
        end
        w_state_d = StExecute;
      end
      StExecute: begin
        // M-type store: acc goes out to data memory instead of being updated.
        if (instr[11:8] == 4'b0010) begin
          dmem_en = 1'b1;
          dmem_we = 1'b1;
        end
        w_state_d = StFetch;
      end
      default: w_state_d = StLoad;
    endcase
  end

  always_comb begin
    w_pc_d     = r_pc;
    w_acc_d    = r_acc;
    w_status_d = r_status;
    if ((r_state == StLoad) && load_done) begin
      w_pc_d     = 8'h00;
      w_acc_d    = 8'h00;
      w_status_d = 4'h0;
    end else if (r_state == StExecute) begin
      if (instr[11]) begin
        w_acc_d    = alu_result;
        w_status_d = w_flags;
        w_pc_d     = w_pc_inc;
      end else if (instr[10]) begin
        w_pc_d = r_status[instr[9:8]] ? instr[7:0] : w_pc_inc;
      end else if (instr[9]) begin
        w_status_d = w_flags;
        w_pc_d     = w_pc_inc;
        if (instr[8]) w_acc_d = alu_result;
      end else if (!instr[8]) begin
        w_pc_d = w_pc_inc;
      end else begin
        w_pc_d = instr[7:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StLoad;
    else     r_state <= w_state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= 8'h00;
      r_acc    <= 8'h00;
      r_status <= 4'h0;
    end else begin
      r_pc     <= w_pc_d;
      r_acc    <= w_acc_d;
      r_status <= w_status_d;
    end
  end

endmodule

// File: tb/tb_mcu_exec_core.sv
// Directed self-checking bench for mcu_exec_core: reset, sequencing, I-type,
// jumps, M-type, every ALU mode and asynchronous reset abort.
module tb_mcu_exec_core;

  logic        clk = 1'b0;
  logic        rst, load_done;
  logic [11:0] instr;
  logic [7:0]  data_in;
  logic [1:0]  state;
  logic [7:0]  pc, acc, alu_result;
  logic [3:0]  status;
  logic        pmem_load_en, ir_en, pmem_en, dr_en, dmem_en, dmem_we;
  logic [5:0]  strb;

  int checks = 0;
  int errors = 0;

  // Expected ALU result and resulting status for acc=0x03, op2=0x81.
  logic [7:0] alu_exp [16] = '{8'h84, 8'h82, 8'h03, 8'h81, 8'h01, 8'h83, 8'h82, 8'h7E,
                               8'h82, 8'h80, 8'h0C, 8'h30, 8'h08, 8'h10, 8'hF0, 8'h7F};
  logic [3:0] st_exp [16]  = '{4'b0010, 4'b0111, 4'b0000, 4'b0010, 4'b0000, 4'b0010,
                               4'b0010, 4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                               4'b0000, 4'b0000, 4'b0010, 4'b0100};

  mcu_exec_core dut (
    .clk          (clk),
    .rst          (rst),
    .load_done    (load_done),
    .instr        (instr),
    .data_in      (data_in),
    .state        (state),
    .pc           (pc),
    .acc          (acc),
    .status       (status),
    .alu_result   (alu_result),
    .pmem_load_en (pmem_load_en),
    .ir_en        (ir_en),
    .pmem_en      (pmem_en),
    .dr_en        (dr_en),
    .dmem_en      (dmem_en),
    .dmem_we      (dmem_we)
  );

  assign strb = {pmem_load_en, ir_en, pmem_en, dr_en, dmem_en, dmem_we};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reset, then one load_done cycle; returns at a negedge with state=FETCH.
  task automatic boot();
    rst       = 1'b1;
    load_done = 1'b0;
    instr     = 12'h000;
    @(negedge clk);
    rst       = 1'b0;
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
  endtask

  // Runs one instruction from FETCH back to FETCH, sampling DECODE/EXECUTE.
  task automatic run_instr(input logic [11:0] ins, output logic [5:0] dec_strb,
                           output logic [5:0] exe_strb, output logic [7:0] exe_alu);
    instr = ins;
    @(negedge clk);
    dec_strb = strb;
    @(negedge clk);
    exe_strb = strb;
    exe_alu  = alu_result;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; load_done = 1'b0; instr = 12'h000; data_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({state, pc, acc, status} !== 22'h0) begin
      errors++;
      $display("FAIL rst_regs: state=%0h pc=%h acc=%h status=%b want all 0",
               state, pc, acc, status);
    end
    checks++;
    if (strb !== 6'b100000) begin
      errors++; $display("FAIL rst_strobes: got %b want 100000", strb);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state !== 2'b00) begin
      errors++; $display("FAIL load_hold: state got %0h want 0", state);
    end
  endtask

  task automatic test_load_fetch();
    load_done = 1'b1; instr = 12'h000;
    @(negedge clk);
    load_done = 1'b0;
    checks++;
    if ({state, strb} !== {2'b01, 6'b011000}) begin
      errors++; $display("FAIL lf_fetch: state=%0h strb=%b want 1 011000", state, strb);
    end
    @(negedge clk);
    checks++;
    if ({state, strb} !== {2'b10, 6'b000000}) begin
      errors++; $display("FAIL lf_decode: state=%0h strb=%b want 2 000000", state, strb);
    end
    @(negedge clk);
    checks++;
    if ({state, strb} !== {2'b11, 6'b000000}) begin
      errors++; $display("FAIL lf_execute: state=%0h strb=%b want 3 000000", state, strb);
    end
    @(negedge clk);
    checks++;
    if ({state, pc} !== {2'b01, 8'h01}) begin
      errors++; $display("FAIL lf_back_fetch: state=%0h pc=%h want 1 01", state, pc);
    end
  endtask

  task automatic test_itype();
    logic [5:0] ds, es;
    logic [7:0] ea;
    boot();
    run_instr(12'h805, ds, es, ea);
    checks++;
    if ({ds, ea, acc, pc, status} !== {6'b0, 8'h05, 8'h05, 8'h01, 4'b0000}) begin
      errors++;
      $display("FAIL itype_add: dec=%b alu=%h acc=%h pc=%h st=%b want 000000 05 05 01 0000",
               ds, ea, acc, pc, status);
    end
    run_instr(12'h905, ds, es, ea);
    checks++;
    if ({acc, status} !== {8'h00, 4'b1000}) begin
      errors++; $display("FAIL itype_sub: acc=%h st=%b want 00 1000", acc, status);
    end
    run_instr(12'hBFF, ds, es, ea);
    checks++;
    if ({acc, status} !== {8'hFF, 4'b0010}) begin
      errors++; $display("FAIL itype_mov: acc=%h st=%b want ff 0010", acc, status);
    end
    run_instr(12'h801, ds, es, ea);
    checks++;
    if ({acc, status} !== {8'h00, 4'b1100}) begin
      errors++; $display("FAIL itype_carry: acc=%h st=%b want 00 1100", acc, status);
    end
  endtask

  task automatic test_jump();
    logic [5:0] ds, es;
    logic [7:0] ea;
    boot();
    run_instr(12'h120, ds, es, ea);
    checks++;
    if (pc !== 8'h20) begin errors++; $display("FAIL goto: pc got %h want 20", pc); end
    run_instr(12'h900, ds, es, ea);
    run_instr(12'h740, ds, es, ea);
    checks++;
    if (pc !== 8'h40) begin errors++; $display("FAIL jz_taken: pc got %h want 40", pc); end
    run_instr(12'h801, ds, es, ea);
    run_instr(12'h740, ds, es, ea);
    checks++;
    if (pc !== 8'h42) begin errors++; $display("FAIL jz_not_taken: pc got %h want 42", pc); end
    run_instr(12'h1FF, ds, es, ea);
    checks++;
    if (pc !== 8'hFF) begin errors++; $display("FAIL goto_ff: pc got %h want ff", pc); end
    run_instr(12'h000, ds, es, ea);
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL pc_wrap: pc got %h want 00", pc); end
    run_instr(12'h9FF, ds, es, ea);
    checks++;
    if ({acc, status, pc} !== {8'h02, 4'b0100, 8'h01}) begin
      errors++; $display("FAIL sub_borrow: acc=%h st=%b pc=%h want 02 0100 01", acc, status, pc);
    end
    run_instr(12'h640, ds, es, ea);
    checks++;
    if ({pc, ea} !== {8'h40, 8'h02}) begin
      errors++; $display("FAIL jc_taken: pc=%h alu=%h want 40 02", pc, ea);
    end
  endtask

  task automatic test_mtype();
    logic [5:0] ds, es;
    logic [7:0] ea;
    boot();
    data_in = 8'h00;
    run_instr(12'h802, ds, es, ea);
    data_in = 8'h03;
    run_instr(12'h301, ds, es, ea);
    checks++;
    if ({ds, es, ea, acc, pc} !== {6'b000110, 6'b000000, 8'h05, 8'h05, 8'h02}) begin
      errors++;
      $display("FAIL mtype_load: dec=%b exe=%b alu=%h acc=%h pc=%h want 000110 000000 05 05 02",
               ds, es, ea, acc, pc);
    end
    run_instr(12'h201, ds, es, ea);
    checks++;
    if ({ds, es, ea, acc, alu_result, status} !==
        {6'b000110, 6'b000011, 8'h08, 8'h05, 8'h05, 4'b0000}) begin
      errors++;
      $display("FAIL mtype_store: dec=%b exe=%b alu=%h acc=%h res=%h st=%b want 000110 000011 08 05 05 0000",
               ds, es, ea, acc, alu_result, status);
    end
    run_instr(12'h3F1, ds, es, ea);
    checks++;
    if ({acc, status} !== {8'hFD, 4'b0110}) begin
      errors++; $display("FAIL mtype_neg: acc=%h st=%b want fd 0110", acc, status);
    end
  endtask

  task automatic test_alu_modes();
    logic [5:0] ds, es;
    logic [7:0] ea;
    boot();
    data_in = 8'h00;
    run_instr(12'h803, ds, es, ea);
    data_in = 8'h81;
    for (int m = 0; m < 16; m++) begin
      run_instr({4'h2, 4'(m), 4'h0}, ds, es, ea);
      checks++;
      if ({ea, status, acc, es} !== {alu_exp[m], st_exp[m], 8'h03, 6'b000011}) begin
        errors++;
        $display("FAIL alu_mode_%0h: alu=%h st=%b acc=%h exe=%b want %h %b 03 000011",
                 m, ea, status, acc, es, alu_exp[m], st_exp[m]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [5:0] ds, es;
    logic [7:0] ea;
    boot();
    run_instr(12'h805, ds, es, ea);
    instr = 12'h801;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({state, pc, acc, status} !== 22'h0) begin
      errors++;
      $display("FAIL async_abort: state=%0h pc=%h acc=%h st=%b want all 0", state, pc, acc, status);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({state, acc, strb} !== {2'b00, 8'h00, 6'b100000}) begin
      errors++;
      $display("FAIL abort_idle: state=%0h acc=%h strb=%b want 0 00 100000", state, acc, strb);
    end
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_itype();
    test_jump();
    test_mtype();
    test_alu_modes();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu_exec_core.md
MCU_EXEC_CORE -- requirements
Module: mcu_exec_core

Interface
REQ-001 Parameters SHALL be: ST_LOAD, 2'b00, load state code; ST_FETCH, 2'b01, fetch state code; ST_DECODE, 2'b10, decode state code; ST_EXECUTE, 2'b11, execute state code.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- load_done  in  1  program-memory load complete
- instr  in  12  current instruction-register contents
- data_in  in  8  data-register value (M-type operand)
- state  out  2  current state
- pc  out  8  program counter
- acc  out  8  accumulator
- status  out  4  status register {Z,C,S,O}
- alu_result  out  8  combinational ALU result
- pmem_load_en, ir_en, pmem_en, dr_en, dmem_en, dmem_we  out  1 each  combinational control strobes

Function
REQ-004 FSM SHALL sequence LOAD->(load_done=1) FETCH->DECODE->EXECUTE->FETCH; LOAD holds while load_done=0.
REQ-005 On the LOAD->FETCH edge, pc, acc and status SHALL clear to 0.
REQ-006 LOAD SHALL assert pmem_load_en only; FETCH SHALL assert ir_en and pmem_en; DECODE SHALL assert dr_en and dmem_en iff instr[11:9]=3'b001; all other strobes 0.
REQ-007 The EXECUTE decode SHALL be prioritised as follows.
- instr[11]=1: I-type; ALU enabled, mode={0,instr[10:8]}, operand2=instr[7:0]; acc and status load; pc<=pc+1.
- else instr[10]=1: conditional jump; pc<=instr[7:0] if status[instr[9:8]]=1, else pc+1.
- else instr[9]=1: M-type; ALU enabled, mode=instr[7:4], operand2=data_in; status loads; pc+1.
- M-type, instr[8]=1: acc loads alu_result.
- M-type, instr[8]=0: dmem_en=dmem_we=1; acc holds.
- else instr[8]=0: NOP; pc+1.
- else: GOTO; pc<=instr[7:0].
REQ-008 Outside EXECUTE, pc, acc and status SHALL hold, and the ALU SHALL be disabled.
REQ-009 The pc adder SHALL compute pc+1 mod 256, so 0xFF wraps to 0x00.
REQ-010 ALU operand1 SHALL be acc.
REQ-011 ALU modes (result mod 256) SHALL be:
- 0: op1+op2
- 1: op1-op2
- 2: op1
- 3: op2
- 4: and
- 5: or
- 6: xor
- 7: op2-op1
- 8: op2+1
- 9: op2-1
- A: rotate op2 left by op1[2:0]
- B: rotate op2 right by op1[2:0]
- C: op2<<op1[2:0]
- D: op2>>op1[2:0] (logical)
- E: op2>>>op1[2:0] (arithmetic)
- F: 0-op2
REQ-012 Z SHALL be result==0, and S SHALL be result[7].
REQ-013 C SHALL be bit 8 of the 9-bit unsigned result for add/increment modes, and the borrow for subtract/decrement/negate modes; O SHALL be two's-complement overflow for those modes.
REQ-014 For modes 2-6 and A-E, C and O SHALL be 0.
REQ-015 When the ALU is disabled, alu_result SHALL equal acc and the flags output SHALL equal status.
REQ-016 All strobes SHALL be a pure combinational function of state, instr and status.

Reset
REQ-017 While rst=1, regardless of clk, the block SHALL force state=ST_LOAD, pc=0, acc=0, status=0.
REQ-018 Reset asserted mid-instruction SHALL abort it, with no acc/status/pc update.

Verification
REQ-019 Reset check: assert rst -> state=00, pc=acc=status=0, pmem_load_en=1, all other strobes 0.
REQ-020 Load/fetch check: load_done=1 for one cycle in LOAD -> FETCH (ir_en=pmem_en=1), then DECODE, then EXECUTE, then FETCH.
REQ-021 I-type check: acc=0, instr=0x805 through EXECUTE -> acc=0x05, pc=1, status=0000.
- Then instr=0x905 -> acc=0x00, Z=1, C=0.
- acc=0xFF with instr=0x801 -> acc=0x00, Z=1, C=1, O=0.
REQ-022 Jump check: instr=0x120 (GOTO) -> pc=0x20.
- Z=1 with instr=0x740 -> pc=0x40.
- Z=0 with instr=0x740 -> pc increments.
- pc=0xFF with NOP -> pc=0x00.
REQ-023 M-type check: data_in=0x03, acc=0x02, instr=0x301 -> DECODE dr_en=dmem_en=1, EXECUTE acc=0x05.
- instr=0x201 -> dmem_en=dmem_we=1, acc unchanged, alu_result=0x05.
